// File: rtl/atm_keypad_entry_if.sv
// -----------------------------------------------------------------------------
// atm_keypad_entry_if
//
// Purpose : Bundles the keypad-side strobes and the controller-side entry
//           fields of the ATM keypad entry block into one interface.
//
// Signals :
//   key_valid        one-cycle key strobe
//   key_code   [3:0] 0-9 digit, 0xA CLEAR, 0xB ENTER, 0xC CANCEL, 0xD-0xF ignored
//   entry_ack        controller has consumed the assembled entry
//   credit_number [9:0]   latched card number
//   password      [9:0]   latched password
//   expiration_date [10:0] latched expiration year
//   entry_valid      all three fields latched, held until ack
//   entry_error      one-cycle pulse on a malformed field
//   exit             one-cycle pulse on cancel (or timeout when enabled)
//   state      [2:0] current FSM state, debug only
//
// Modports:
//   master : keypad / controller side (drives keys and ack)
//   slave  : atm_keypad_entry side (drives fields and status)
// -----------------------------------------------------------------------------
interface atm_keypad_entry_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        entry_ack;
   logic [9:0]  credit_number;
   logic [9:0]  password;
   logic [10:0] expiration_date;
   logic        entry_valid;
   logic        entry_error;
   logic        exit;
   logic [2:0]  state;

   modport master (
      output key_valid, key_code, entry_ack,
      input  credit_number, password, expiration_date,
      input  entry_valid, entry_error, exit, state
   );

   modport slave (
      input  key_valid, key_code, entry_ack,
      output credit_number, password, expiration_date,
      output entry_valid, entry_error, exit, state
   );
endinterface

// File: rtl/atm_keypad_entry.sv
// -----------------------------------------------------------------------------
// atm_keypad_entry
//
// Purpose : Front end of the ATM transaction controller. Collects decimal
//           keypad digits and assembles card number, password and expiration
//           year in that fixed order, then presents them with a ready
//           handshake (entry_valid / entry_ack). CANCEL produces a one-cycle
//           exit pulse; a malformed field produces a one-cycle entry_error.
//
// Ports   :
//   clock    input   system clock, rising edge
//   reset_n  input   asynchronous active-low reset
//   bus      slave   atm_keypad_entry_if (keys, ack, fields, status)
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles before automatic exit (timeout build only,
//                   must be >= 2)
//   MAX_DIGITS      maximum digits per field, exact digit count for the year
//
// Build option:
//   ATM_KEYPAD_TIMEOUT_EN  when defined, a 16-bit idle counter forces an
//                          exit after TIMEOUT_CYCLES cycles without a key
//                          while an entry is in progress or awaiting ack.
// -----------------------------------------------------------------------------
module atm_keypad_entry #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_DIGITS     = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   atm_keypad_entry_if.slave   bus
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CARD  = 3'd1,
      S_PASS  = 3'd2,
      S_DATE  = 3'd3,
      S_READY = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   // acc*10 + digit; MAX_DIGITS bounds acc to 9999 so 14 bits never wrap
   function automatic logic [13:0] acc_push(input logic [13:0] acc,
                                            input logic [3:0]  digit);
      return (acc * 14'd10) + {10'd0, digit};
   endfunction

   state_t             state_q, state_nxt;
   logic [13:0]        acc_q, acc_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic [9:0]         credit_q, credit_nxt;
   logic [9:0]         pass_q, pass_nxt;
   logic [10:0]        date_q, date_nxt;
   logic               valid_q, valid_nxt;
   logic               error_q, error_nxt;
   logic               exit_q, exit_nxt;

   logic               key_digit, key_clear, key_enter, key_cancel;
   logic               range_bad;
   logic               tmo_fire;

   assign key_digit  = bus.key_valid && (bus.key_code <= 4'd9);
   assign key_clear  = bus.key_valid && (bus.key_code == 4'hA);
   assign key_enter  = bus.key_valid && (bus.key_code == 4'hB);
   assign key_cancel = bus.key_valid && (bus.key_code == 4'hC);

   // Card and password fit 10 bits, the year fits 11 bits
   assign range_bad = (state_q == S_DATE) ? (acc_q > 14'd2047)
                                          : (acc_q > 14'd1023);

`ifdef ATM_KEYPAD_TIMEOUT_EN
   logic [15:0] idle_cnt_q;
   logic [15:0] idle_cnt_inc;
   logic        counting;

   assign counting     = (state_q == S_CARD) || (state_q == S_PASS) ||
                         (state_q == S_DATE) || (state_q == S_READY);
   assign idle_cnt_inc = idle_cnt_q + 16'd1;
   // Fires on the edge where the count reaches TIMEOUT_CYCLES-1; a key in
   // the same cycle wins and simply restarts the count.
   assign tmo_fire     = counting && !bus.key_valid &&
                         (idle_cnt_inc == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt_q <= 16'd0;
      end else if (bus.key_valid || !counting || tmo_fire) begin
         idle_cnt_q <= 16'd0;
      end else begin
         idle_cnt_q <= idle_cnt_inc;
      end
   end
`else
   // No idle counter: the FSM waits indefinitely for keys or ack
   assign tmo_fire = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      acc_nxt    = acc_q;
      cnt_nxt    = cnt_q;
      credit_nxt = credit_q;
      pass_nxt   = pass_q;
      date_nxt   = date_q;
      exit_nxt   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (key_digit) begin
               state_nxt = S_CARD;
               acc_nxt   = {10'd0, bus.key_code};
               cnt_nxt   = CNT_W'(1);
            end
         end

         S_CARD, S_PASS, S_DATE: begin
            if (key_digit) begin
               // Digits beyond MAX_DIGITS are dropped without error
               if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                  acc_nxt = acc_push(acc_q, bus.key_code);
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end else if (key_clear) begin
               acc_nxt = 14'd0;
               cnt_nxt = '0;
            end else if (key_enter && (cnt_q != '0)) begin
               if (range_bad ||
                   ((state_q == S_DATE) && (cnt_q != CNT_W'(MAX_DIGITS)))) begin
                  state_nxt = S_ERROR;
               end else begin
                  acc_nxt = 14'd0;
                  cnt_nxt = '0;
                  case (state_q)
                     S_CARD: begin
                        credit_nxt = acc_q[9:0];
                        state_nxt  = S_PASS;
                     end
                     S_PASS: begin
                        pass_nxt  = acc_q[9:0];
                        state_nxt = S_DATE;
                     end
                     default: begin
                        date_nxt  = acc_q[10:0];
                        state_nxt = S_READY;
                     end
                  endcase
               end
            end else if (key_cancel || tmo_fire) begin
               state_nxt  = S_IDLE;
               exit_nxt   = 1'b1;
               acc_nxt    = 14'd0;
               cnt_nxt    = '0;
               credit_nxt = 10'd0;
               pass_nxt   = 10'd0;
               date_nxt   = 11'd0;
            end
         end

         S_READY: begin
            // CANCEL takes priority over a simultaneous ack
            if (key_cancel || tmo_fire) begin
               state_nxt  = S_IDLE;
               exit_nxt   = 1'b1;
               credit_nxt = 10'd0;
               pass_nxt   = 10'd0;
               date_nxt   = 11'd0;
            end else if (bus.entry_ack) begin
               // Fields are retained until the next card ENTER
               state_nxt = S_IDLE;
            end
         end

         S_ERROR: begin
            // Any key arriving in this cycle is discarded
            state_nxt  = S_IDLE;
            acc_nxt    = 14'd0;
            cnt_nxt    = '0;
            credit_nxt = 10'd0;
            pass_nxt   = 10'd0;
            date_nxt   = 11'd0;
         end

         default: begin
            state_nxt = S_IDLE;
            acc_nxt   = 14'd0;
            cnt_nxt   = '0;
         end
      endcase

      // Status flags follow the state being entered, giving 1-cycle latency
      valid_nxt = (state_nxt == S_READY);
      error_nxt = (state_nxt == S_ERROR);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_q    <= 14'd0;
         cnt_q    <= '0;
         credit_q <= 10'd0;
         pass_q   <= 10'd0;
         date_q   <= 11'd0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         exit_q   <= 1'b0;
      end else begin
         acc_q    <= acc_nxt;
         cnt_q    <= cnt_nxt;
         credit_q <= credit_nxt;
         pass_q   <= pass_nxt;
         date_q   <= date_nxt;
         valid_q  <= valid_nxt;
         error_q  <= error_nxt;
         exit_q   <= exit_nxt;
      end
   end

   assign bus.credit_number   = credit_q;
   assign bus.password        = pass_q;
   assign bus.expiration_date = date_q;
   assign bus.entry_valid     = valid_q;
   assign bus.entry_error     = error_q;
   assign bus.exit            = exit_q;
   assign bus.state           = state_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// -----------------------------------------------------------------------------
// tb_atm_keypad_entry
//
// Self-checking bench for atm_keypad_entry. Expected entry_valid / entry_error
// / exit events are queued when the stimulus that causes them is driven and
// are popped by a monitor when the DUT raises them. Direct state/field checks
// are made #1 after the clock edge that processes a key.
// -----------------------------------------------------------------------------
module tb_atm_keypad_entry;

   localparam int EV_VALID = 1;
   localparam int EV_ERR   = 2;
   localparam int EV_EXIT  = 3;

   typedef struct {
      int kind;
      int c;
      int p;
      int d;
   } ev_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   atm_keypad_entry_if bus();

   atm_keypad_entry #(
      .TIMEOUT_CYCLES(20),
      .MAX_DIGITS    (4)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   int   n_checks = 0;
   int   n_fail   = 0;
   ev_t  sb[$];
   logic valid_prev = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic expect_ev(input int kind, input int c, input int p, input int d);
      ev_t e;
      e.kind = kind;
      e.c    = c;
      e.p    = p;
      e.d    = d;
      sb.push_back(e);
   endtask

   task automatic handle_ev(input int kind);
      ev_t e;
      if (sb.size() == 0) begin
         check_eq("sb_unexpected_event", kind, 0);
      end else begin
         e = sb.pop_front();
         check_eq("sb_event_kind", kind, e.kind);
         if (kind == EV_ERR) begin
            check_eq("sb_err_state", bus.state, 5);
         end else begin
            check_eq("sb_credit", bus.credit_number, e.c);
            check_eq("sb_password", bus.password, e.p);
            check_eq("sb_date", bus.expiration_date, e.d);
         end
      end
   endtask

   // Monitor: one event per high cycle of exit/entry_error, one per rise of
   // entry_valid
   always @(negedge clock) begin
      if (!reset_n) begin
         valid_prev = 1'b0;
      end else begin
         if (bus.exit)                        handle_ev(EV_EXIT);
         if (bus.entry_error)                 handle_ev(EV_ERR);
         if (bus.entry_valid && !valid_prev)  handle_ev(EV_VALID);
         valid_prev = bus.entry_valid;
      end
   end

   task automatic press(input logic [3:0] code);
      @(posedge clock);
      #1;
      bus.key_valid = 1'b1;
      bus.key_code  = code;
      @(posedge clock);
      #1;
      bus.key_valid = 1'b0;
   endtask

   task automatic press_num(input int v, input int n);
      int d;
      for (int i = n - 1; i >= 0; i--) begin
         d = (v / (10 ** i)) % 10;
         press(4'(d));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic full_entry(input int c, input int p, input int d);
      expect_ev(EV_VALID, c, p, d);
      press_num(c, 4);
      press(4'hB);
      press_num(p, 4);
      press(4'hB);
      press_num(d, 4);
      press(4'hB);
   endtask

   initial begin
      int  n;
      logic saw;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'd0;
      bus.entry_ack = 1'b0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_state", bus.state, 0);
      check_eq("rst_credit", bus.credit_number, 0);
      check_eq("rst_password", bus.password, 0);
      check_eq("rst_date", bus.expiration_date, 0);
      check_eq("rst_valid", bus.entry_valid, 0);
      check_eq("rst_error", bus.entry_error, 0);
      check_eq("rst_exit", bus.exit, 0);
      @(negedge clock);
      reset_n = 1'b1;

      // Normal entry, ack three cycles after last ENTER
      expect_ev(EV_VALID, 200, 200, 2025);
      press_num(200, 3);
      press(4'hD);
      press(4'hB);
      check_eq("card_to_pass", bus.state, 2);
      check_eq("card_latched", bus.credit_number, 200);
      press_num(200, 3);
      press(4'hB);
      check_eq("pass_to_date", bus.state, 3);
      check_eq("pass_latched", bus.password, 200);
      press_num(2025, 4);
      press(4'hB);
      check_eq("valid_latency", bus.entry_valid, 1);
      check_eq("ready_state", bus.state, 4);
      idle(2);
      bus.entry_ack = 1'b1;
      check_eq("valid_before_ack", bus.entry_valid, 1);
      @(posedge clock);
      #1;
      bus.entry_ack = 1'b0;
      check_eq("valid_after_ack", bus.entry_valid, 0);
      check_eq("ack_to_idle", bus.state, 0);
      check_eq("ack_keeps_credit", bus.credit_number, 200);
      check_eq("ack_keeps_date", bus.expiration_date, 2025);
      check_eq("normal_no_exit", bus.exit, 0);
      check_eq("normal_no_error", bus.entry_error, 0);

      // Digit limit and range error
      press_num(10007, 5);
      press(4'hB);
      check_eq("digit_limit_credit", bus.credit_number, 1000);
      check_eq("digit_limit_state", bus.state, 2);
      expect_ev(EV_ERR, 0, 0, 0);
      press_num(1024, 4);
      press(4'hB);
      check_eq("pass_range_state", bus.state, 5);
      check_eq("pass_range_error", bus.entry_error, 1);
      idle(1);
      check_eq("err_idle", bus.state, 0);
      check_eq("err_credit_clr", bus.credit_number, 0);
      check_eq("err_pass_clr", bus.password, 0);
      check_eq("err_date_clr", bus.expiration_date, 0);
      check_eq("err_pulse_end", bus.entry_error, 0);

      // Year too short, with a key landing in the ERROR cycle
      press(4'd1);
      press(4'hB);
      press(4'd2);
      press(4'hB);
      expect_ev(EV_ERR, 0, 0, 0);
      press_num(202, 3);
      press(4'hB);
      check_eq("year_short", bus.state, 5);
      bus.key_valid = 1'b1;
      bus.key_code  = 4'd5;
      @(posedge clock);
      #1;
      bus.key_valid = 1'b0;
      check_eq("err_key_drop", bus.state, 0);
      check_eq("err_key_credit", bus.credit_number, 0);

      // Year out of range
      press(4'd1);
      press(4'hB);
      press(4'd2);
      press(4'hB);
      expect_ev(EV_ERR, 0, 0, 0);
      press_num(9999, 4);
      press(4'hB);
      check_eq("year_range", bus.state, 5);
      idle(1);

      // Clear, empty ENTER, cancel
      press_num(50, 2);
      press(4'hA);
      press(4'hB);
      check_eq("enter_empty", bus.state, 1);
      press_num(300, 3);
      press(4'hB);
      check_eq("clear_credit", bus.credit_number, 300);
      press(4'd7);
      expect_ev(EV_EXIT, 0, 0, 0);
      press(4'hC);
      check_eq("cancel_exit", bus.exit, 1);
      check_eq("cancel_credit", bus.credit_number, 0);
      check_eq("cancel_state", bus.state, 0);
      idle(1);
      check_eq("cancel_exit_end", bus.exit, 0);
      press(4'hC);
      check_eq("idle_cancel_ignored", bus.exit, 0);

      // READY ignores keys; CANCEL beats a simultaneous ack
      full_entry(12, 34, 2000);
      check_eq("ready_reached", bus.state, 4);
      press(4'd5);
      press(4'hA);
      press(4'hB);
      check_eq("ready_ignore_state", bus.state, 4);
      check_eq("ready_ignore_date", bus.expiration_date, 2000);
      expect_ev(EV_EXIT, 0, 0, 0);
      @(posedge clock);
      #1;
      bus.key_valid = 1'b1;
      bus.key_code  = 4'hC;
      bus.entry_ack = 1'b1;
      @(posedge clock);
      #1;
      bus.key_valid = 1'b0;
      bus.entry_ack = 1'b0;
      check_eq("cancel_ack_exit", bus.exit, 1);
      check_eq("cancel_ack_valid", bus.entry_valid, 0);
      check_eq("cancel_ack_date", bus.expiration_date, 0);

      // Asynchronous reset mid-entry
      press_num(77, 2);
      press(4'hB);
      press_num(88, 2);
      press(4'hB);
      press_num(12, 2);
      check_eq("pre_reset_state", bus.state, 3);
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check_eq("async_rst_state", bus.state, 0);
      check_eq("async_rst_credit", bus.credit_number, 0);
      check_eq("async_rst_password", bus.password, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      full_entry(123, 45, 1999);
      check_eq("post_reset_ready", bus.state, 4);
      @(posedge clock);
      #1;
      bus.entry_ack = 1'b1;
      @(posedge clock);
      #1;
      bus.entry_ack = 1'b0;
      check_eq("post_reset_ack", bus.state, 0);

      // Idle timeout
      press_num(400, 3);
      press(4'hB);
      check_eq("tmo_card", bus.credit_number, 400);
`ifdef ATM_KEYPAD_TIMEOUT_EN
      expect_ev(EV_EXIT, 0, 0, 0);
      n = 1;
      while (!bus.exit && n < 40) begin
         @(posedge clock);
         #1;
         n++;
      end
      check_eq("tmo_latency", n, 20);
      check_eq("tmo_credit", bus.credit_number, 0);
      check_eq("tmo_state", bus.state, 0);
`else
      saw = 1'b0;
      n   = 0;
      repeat (1000) begin
         @(posedge clock);
         #1;
         n++;
         if (bus.exit) saw = 1'b1;
      end
      check_eq("no_tmo_exit", saw, 0);
      check_eq("no_tmo_state", bus.state, 2);
      expect_ev(EV_EXIT, 0, 0, 0);
      press(4'hC);
`endif

      idle(2);
      check_eq("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
